// File: rtl/pp_row_accumulator.sv
// Sequential partial-product row accumulator: one adder and a row counter sum
// the radix-4 partial-product rows of a mantissa product, then hold the result.
module pp_row_accumulator #(
  parameter int unsigned N    = 24,
  parameter int unsigned ROWS = 12,
  parameter int unsigned CW   = 4
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_in_valid,
  output logic            o_in_ready,
  input  logic [2*N-1:0]  i_in_row,
  input  logic            i_in_last,
  output logic            o_out_valid,
  input  logic            i_out_ready,
  output logic [2*N-1:0]  o_out_product,
  output logic [CW-1:0]   o_out_rows,
  output logic            o_out_short
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [2*N-1:0]  r_acc;
  logic [2*N-1:0]  w_acc_nxt;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [2*N-1:0]  w_sum;
  logic [CW-1:0]   w_cnt_inc;
  logic            w_accept;
  logic            w_done;

  assign w_done    = (r_state == S_DONE);
  assign w_accept  = i_in_valid & o_in_ready;
  // Carry-out is intentionally dropped: the product is defined modulo 2^(2N).
  assign w_sum     = r_acc + i_in_row;
  assign w_cnt_inc = r_cnt + CW'(1);

  assign o_in_ready    = ~w_done;
  assign o_out_valid   = w_done;
  assign o_out_product = w_done ? r_acc : '0;
  assign o_out_rows    = w_done ? r_cnt : '0;
  assign o_out_short   = w_done && (r_cnt < CW'(ROWS));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_acc_nxt   = i_in_row;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = (i_in_last || (ROWS == 1)) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = w_sum;
          w_cnt_nxt = w_cnt_inc;
          if (i_in_last || (w_cnt_inc == CW'(ROWS))) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Result is held untouched until the normalisation stage takes it.
        if (i_out_ready) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pp_row_accumulator.sv
// Directed bench for pp_row_accumulator: a bench-side model pushes expected
// products onto a scoreboard queue that is drained as the DUT emits them.
module tb_pp_row_accumulator;

  localparam int N    = 24;
  localparam int ROWS = 12;
  localparam int CW   = 4;

  typedef struct packed {
    logic [2*N-1:0] product;
    logic [CW-1:0]  rows;
    logic           isShort;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           inValid = 1'b0;
  logic           inReady;
  logic [2*N-1:0] inRow = '0;
  logic           inLast = 1'b0;
  logic           outValid;
  logic           outReady = 1'b0;
  logic [2*N-1:0] outProduct;
  logic [CW-1:0]  outRows;
  logic           outShort;

  exp_t           sb[$];
  logic [2*N-1:0] modelAcc = '0;
  int             modelCnt = 0;
  int             nChecks = 0;
  int             nErrors = 0;

  pp_row_accumulator #(.N(N), .ROWS(ROWS), .CW(CW)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_in_valid(inValid),
    .o_in_ready(inReady),
    .i_in_row(inRow),
    .i_in_last(inLast),
    .o_out_valid(outValid),
    .i_out_ready(outReady),
    .o_out_product(outProduct),
    .o_out_rows(outRows),
    .o_out_short(outShort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nErrors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one row for a single clock edge (called at a negedge) and update the model.
  task automatic applyStimulus(input logic [2*N-1:0] row, input logic last);
    inValid = 1'b1;
    inRow   = row;
    inLast  = last;
    chk("in_ready_at_offer", 64'(inReady), 64'(1));
    @(posedge clk);
    modelAcc = (modelCnt == 0) ? row : modelAcc + row;
    modelCnt++;
    if (last || modelCnt == ROWS) begin
      sb.push_back('{product: modelAcc, rows: CW'(modelCnt), isShort: (modelCnt < ROWS)});
      modelAcc = '0;
      modelCnt = 0;
    end
    @(negedge clk);
  endtask

  task automatic dropInputs();
    inValid = 1'b0;
    inLast  = 1'b0;
    inRow   = '0;
  endtask

  task automatic popCompare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      nChecks++;
      nErrors++;
      $error("[TB] FAIL %s_scoreboard: observed=empty queue expected=pending product", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_product"}, 64'(outProduct), 64'(e.product));
      chk({tag, "_rows"}, 64'(outRows), 64'(e.rows));
      chk({tag, "_short"}, 64'(outShort), 64'(e.isShort));
    end
  endtask

  // Wait (bounded) for a product, compare it, then perform the output handshake.
  task automatic checkOutput(input string tag);
    int waitCycles = 0;
    while (!outValid && waitCycles < 50) begin
      @(negedge clk);
      waitCycles++;
    end
    chk({tag, "_out_valid"}, 64'(outValid), 64'(1));
    chk({tag, "_in_ready_done"}, 64'(inReady), 64'(0));
    popCompare(tag);
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    chk({tag, "_in_ready_after"}, 64'(inReady), 64'(1));
    chk({tag, "_out_valid_after"}, 64'(outValid), 64'(0));
  endtask

  task automatic resetModel();
    modelAcc = '0;
    modelCnt = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(outValid), 64'(0));
    chk("rst_out_product", 64'(outProduct), 64'(0));
    chk("rst_out_rows", 64'(outRows), 64'(0));
    chk("rst_out_short", 64'(outShort), 64'(0));
    chk("rst_in_ready", 64'(inReady), 64'(1));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Rows 1..12 back to back; out_valid must be up right after the 12th accept
    for (int i = 1; i <= ROWS; i++) applyStimulus(48'(i), 1'b0);
    dropInputs();
    chk("seq_latency_valid", 64'(outValid), 64'(1));
    chk("seq_expected_78", 64'(outProduct), 64'(78));
    checkOutput("seq1to12");

    // -1 then zeros
    applyStimulus(48'hFFFF_FFFF_FFFF, 1'b0);
    for (int i = 0; i < ROWS - 1; i++) applyStimulus('0, 1'b0);
    dropInputs();
    checkOutput("minus_one");

    // Two half-range rows: carry out of bit 47 is dropped
    applyStimulus(48'h8000_0000_0000, 1'b0);
    applyStimulus(48'h8000_0000_0000, 1'b0);
    for (int i = 0; i < ROWS - 2; i++) applyStimulus('0, 1'b0);
    dropInputs();
    chk("wrap_expected_zero", 64'(outProduct), 64'(0));
    checkOutput("wrap");

    // Short product closed by in_last, with idle gaps between rows
    applyStimulus(48'd5, 1'b0);
    dropInputs();
    repeat (3) @(negedge clk);
    chk("idle_hold_valid", 64'(outValid), 64'(0));
    applyStimulus(48'd6, 1'b0);
    applyStimulus(48'd7, 1'b1);
    dropInputs();
    chk("short_expected_18", 64'(outProduct), 64'(18));
    checkOutput("short3");

    // Single-row product starts from a clean accumulator
    applyStimulus(48'd9, 1'b1);
    dropInputs();
    checkOutput("single_last");

    // in_last on row ROWS is a normal completion
    for (int i = 1; i <= ROWS; i++) applyStimulus(48'd1, (i == ROWS));
    dropInputs();
    checkOutput("last_on_final");

    // Back-pressure: held row must not be consumed while DONE
    for (int i = 1; i <= ROWS; i++) applyStimulus(48'd1, 1'b0);
    inValid = 1'b1;
    inRow   = 48'd100;
    inLast  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("stall_out_valid", 64'(outValid), 64'(1));
      chk("stall_product", 64'(outProduct), 64'(12));
      chk("stall_rows", 64'(outRows), 64'(12));
      chk("stall_in_ready", 64'(inReady), 64'(0));
      @(negedge clk);
    end
    popCompare("stall");
    outReady = 1'b1;
    @(posedge clk);
    @(negedge clk);
    outReady = 1'b0;
    chk("stall_in_ready_after", 64'(inReady), 64'(1));
    applyStimulus(48'd100, 1'b0);
    for (int i = 0; i < ROWS - 1; i++) applyStimulus('0, 1'b0);
    dropInputs();
    chk("held_row_first", 64'(outProduct), 64'(100));
    checkOutput("held_row");

    // Reset in DONE clears outputs asynchronously
    for (int i = 1; i <= ROWS; i++) applyStimulus(48'd3, 1'b0);
    dropInputs();
    #2 rst = 1'b1;
    #1;
    chk("async_done_valid", 64'(outValid), 64'(0));
    chk("async_done_product", 64'(outProduct), 64'(0));
    chk("async_done_in_ready", 64'(inReady), 64'(1));
    void'(sb.pop_back());
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset mid-product discards the accepted rows
    for (int i = 0; i < 5; i++) applyStimulus(48'd7, 1'b0);
    dropInputs();
    #2 rst = 1'b1;
    #1;
    chk("async_mid_valid", 64'(outValid), 64'(0));
    chk("async_mid_rows", 64'(outRows), 64'(0));
    resetModel();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < ROWS; i++) applyStimulus(48'd2, 1'b0);
    dropInputs();
    chk("after_reset_24", 64'(outProduct), 64'(24));
    checkOutput("after_reset");

    // out_ready outside DONE has no effect
    outReady = 1'b1;
    applyStimulus(48'd4, 1'b0);
    applyStimulus(48'd4, 1'b1);
    outReady = 1'b0;
    dropInputs();
    checkOutput("stray_ready");

    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/pp_row_accumulator.md
Name: pp_row_accumulator

Overview:
- Sequential downstream stage for the approximate radix-4 partial-product encoders in the 24-bit mantissa multiplier of the 32-bit floating-point datapath.
- Accepts one pre-shifted, sign-extended 2N-bit partial-product row per handshake.
- Sums the rows modulo 2^(2N) and presents the finished mantissa product on a valid/ready output for the normalisation stage.
- Replaces a wide combinational adder tree with one adder plus a row counter.

Parameters:
- N, 24, multiplicand width; rows and product are 2N bits.
- ROWS, 12, number of rows per product (N/2 radix-4 groups); must be 1..2^CW-1.
- CW, 4, row-counter width; must satisfy 2^CW > ROWS.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_row/in_last are valid.
- in_ready  output  1  block can accept a row this cycle.
- in_row  input  2N  partial-product row, already sign-extended and shifted to its weight.
- in_last  input  1  marks the final row of the product; may end a product early.
- out_valid  output  1  out_product/out_rows/out_short are valid.
- out_ready  input  1  consumer accepts the product.
- out_product  output  2N  accumulated sum modulo 2^(2N).
- out_rows  output  CW  number of rows summed into out_product.
- out_short  output  1  product closed by in_last before ROWS rows.

Behaviour:
- Reset (async assert, synchronous-edge release):
  - state=IDLE, acc=0, cnt=0.
  - out_valid=0, out_product=0, out_rows=0, out_short=0, in_ready=1.
  - Reset mid-product discards all accepted rows; nothing is emitted.
- A row is accepted when in_valid & in_ready at a rising edge. An output is taken when out_valid & out_ready at a rising edge.
- States:
  - IDLE: in_ready=1, acc=0, cnt=0. Accepting a row loads acc=in_row, cnt=1, then goes to ACCUM. If in_last=1 or ROWS=1, goes to DONE instead.
  - ACCUM: in_ready=1. Each accepted row does acc<=acc+in_row (2N-bit wrap, carry-out dropped) and cnt<=cnt+1. Goes to DONE when the new cnt==ROWS or in_last=1. With no in_valid, acc and cnt hold indefinitely.
  - DONE: in_ready=0, out_valid=1. out_product=acc and out_rows=cnt. out_short=1 iff cnt<ROWS. All outputs stay stable until the output handshake. On the handshake: acc=0, cnt=0, go to IDLE.
- Latency: out_valid rises on the first cycle after the closing row is accepted. in_ready returns to 1 on the first cycle after the output handshake. There is no bypass, so maximum throughput is one product per ROWS+1 cycles.
- Boundary cases:
  - in_last on row ROWS: normal completion, out_short=0.
  - in_last is ignored while in_ready=0 (no acceptance).
  - Rows offered while in DONE are not accepted; the upstream holds them.
  - Arithmetic is pure two's-complement modulo 2^(2N). There is no saturation and no overflow flag.
  - out_ready asserted outside DONE has no effect.

Test Plan:
- N=24, ROWS=12: rows 1..12 back-to-back with in_last=0 -> out_valid one cycle after the 12th accept; out_product=78, out_rows=12, out_short=0; in_ready=0 in DONE.
- Row 0xFFFF_FFFF_FFFF (-1) followed by 11 zero rows -> out_product=0xFFFF_FFFF_FFFF, out_rows=12.
- Two rows of 0x8000_0000_0000 followed by 10 zero rows -> carry dropped; out_product=0x0000_0000_0000.
- Rows 5, 6, 7 with in_last=1 on 7 -> out_product=18, out_rows=3, out_short=1; the next product starts from acc=0.
- Complete a product, hold out_ready=0 for 5 cycles while in_valid=1 -> outputs stable, in_ready=0, no rows consumed. Then assert out_ready for 1 cycle -> next cycle in_ready=1 and the held row is accepted as row 1.
- Accept 5 rows, pulse rst mid-cycle -> outputs go to 0 asynchronously. Then 12 rows of 2 -> out_product=24 (no residue from the earlier rows).
